// File: rtl/btn_trigger_pkg.sv
// Shared state encodings and default timing constants for the button trigger.
package btn_trigger_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE         = 2'd0;
    localparam state_t ST_PRESS_WAIT   = 2'd1;
    localparam state_t ST_HELD         = 2'd2;
    localparam state_t ST_RELEASE_WAIT = 2'd3;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CNT_W           = 20;
    localparam int DEF_REPEAT_EN       = 1;
    localparam int DEF_REPEAT_DELAY    = 10;
    localparam int DEF_REPEAT_PERIOD   = 5;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous board inputs; q is the second flop.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/btn_trigger.sv
// Debounced push-button trigger: synchronize, qualify press/release over
// DEBOUNCE_CYCLES samples, emit one-cycle pulses with optional auto-repeat.
module btn_trigger
    import btn_trigger_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int REPEAT_EN       = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic t,
    output logic level
);
    localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DLY_C = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PER_C = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic             btn_s;
    state_t           state, state_n;
    logic [CNT_W-1:0] dcnt, dcnt_n, dcnt_inc;
    logic [CNT_W-1:0] rcnt, rcnt_n, rcnt_inc;
    logic [CNT_W-1:0] rep_target;
    logic             rep, rep_n;
    logic             t_n, level_n;

    sync2 #(.W(1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_s)
    );

    // Saturating increments: counters stick at all-ones instead of wrapping.
    assign dcnt_inc = (&dcnt) ? dcnt : dcnt + ONE_C;
    assign rcnt_inc = (&rcnt) ? rcnt : rcnt + ONE_C;

    // rep marks that the first repeat has fired; later repeats use the period.
    assign rep_target = rep ? PER_C : DLY_C;

    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        rcnt_n  = rcnt;
        rep_n   = rep;
        t_n     = 1'b0;
        level_n = level;
        case (state)
            ST_IDLE: begin
                if (btn_s) begin
                    state_n = ST_PRESS_WAIT;
                    dcnt_n  = ONE_C;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_n = ST_IDLE;
                    dcnt_n  = '0;
                end else if (dcnt_inc >= DEB_C) begin
                    state_n = ST_HELD;
                    t_n     = 1'b1;
                    level_n = 1'b1;
                    dcnt_n  = '0;
                    rcnt_n  = '0;
                    rep_n   = 1'b0;
                end else begin
                    dcnt_n = dcnt_inc;
                end
            end
            ST_HELD: begin
                // Release takes priority over a coincident repeat pulse.
                if (!btn_s) begin
                    state_n = ST_RELEASE_WAIT;
                    dcnt_n  = ONE_C;
                end else if (REPEAT_EN != 0) begin
                    // The !t term keeps pulses one cycle apart when a delay of 1 is used.
                    if (rcnt_inc >= rep_target && !t) begin
                        t_n    = 1'b1;
                        rcnt_n = '0;
                        rep_n  = 1'b1;
                    end else begin
                        rcnt_n = rcnt_inc;
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                if (btn_s) begin
                    state_n = ST_HELD;
                    dcnt_n  = '0;
                    rcnt_n  = '0;
                    rep_n   = 1'b0;
                end else if (dcnt_inc >= DEB_C) begin
                    state_n = ST_IDLE;
                    level_n = 1'b0;
                    dcnt_n  = '0;
                end else begin
                    dcnt_n = dcnt_inc;
                end
            end
            default: begin
                state_n = ST_IDLE;
                dcnt_n  = '0;
                rcnt_n  = '0;
                rep_n   = 1'b0;
                level_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            dcnt  <= '0;
            rcnt  <= '0;
            rep   <= 1'b0;
            t     <= 1'b0;
            level <= 1'b0;
        end else begin
            state <= state_n;
            dcnt  <= dcnt_n;
            rcnt  <= rcnt_n;
            rep   <= rep_n;
            t     <= t_n;
            level <= level_n;
        end
    end
endmodule

// File: tb/tb_btn_trigger.sv
// Bench for btn_trigger: repeat-enabled and repeat-disabled instances share one button.
module tb_btn_trigger;
    logic clk = 1'b0;
    logic reset;
    logic btn_raw;
    logic t_r, level_r, t_nr, level_nr;

    int cyc    = 0;
    int checks = 0;
    int passes = 0;
    int q_r[$];
    int q_nr[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    btn_trigger #(.DEBOUNCE_CYCLES(4), .CNT_W(20), .REPEAT_EN(1),
                  .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut_r (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .t(t_r), .level(level_r));

    btn_trigger #(.DEBOUNCE_CYCLES(4), .CNT_W(20), .REPEAT_EN(0),
                  .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut_nr (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .t(t_nr), .level(level_nr));

    // Scoreboard: each queue holds the absolute edge numbers after which t must be high.
    always @(negedge clk) begin
        if (t_r === 1'b1) begin
            checks++;
            if (q_r.size() > 0 && q_r[0] == cyc) begin
                passes++;
                void'(q_r.pop_front());
            end else
                $display("FAIL t_r_pulse: pulse after edge %0d, expected next at %0d",
                         cyc, (q_r.size() > 0) ? q_r[0] : -1);
        end else if (q_r.size() > 0 && q_r[0] <= cyc) begin
            checks++;
            $display("FAIL t_r_missing: t=%b after edge %0d, expected 1", t_r, q_r[0]);
            void'(q_r.pop_front());
        end
        if (t_nr === 1'b1) begin
            checks++;
            if (q_nr.size() > 0 && q_nr[0] == cyc) begin
                passes++;
                void'(q_nr.pop_front());
            end else
                $display("FAIL t_nr_pulse: pulse after edge %0d, expected next at %0d",
                         cyc, (q_nr.size() > 0) ? q_nr[0] : -1);
        end else if (q_nr.size() > 0 && q_nr[0] <= cyc) begin
            checks++;
            $display("FAIL t_nr_missing: t=%b after edge %0d, expected 1", t_nr, q_nr[0]);
            void'(q_nr.pop_front());
        end
    end

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            btn_raw = (k % 2 == 0);
            @(negedge clk);
            checks++;
            if (t_r !== 1'b0 || t_nr !== 1'b0 || level_r !== 1'b0 || level_nr !== 1'b0)
                $display("FAIL reset_hold cycle %0d: t=%b/%b level=%b/%b, expected all 0",
                         k, t_r, t_nr, level_r, level_nr);
            else passes++;
        end
        btn_raw = 1'b0;
        reset   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (t_r !== 1'b0 || t_nr !== 1'b0 || level_r !== 1'b0 || level_nr !== 1'b0)
                $display("FAIL reset_release cycle %0d: t=%b/%b level=%b/%b, expected all 0",
                         k, t_r, t_nr, level_r, level_nr);
            else passes++;
        end
    endtask

    task automatic test_clean_press();
        int base;
        logic exp;
        base = cyc + 1;
        q_r.push_back(base + 5);
        q_nr.push_back(base + 5);
        for (int k = 0; k < 20; k++) begin
            btn_raw = (k < 8);
            @(negedge clk);
            exp = (k >= 5 && k < 13);
            checks++;
            if (level_r !== exp || level_nr !== exp)
                $display("FAIL clean_level edge %0d: level=%b/%b, expected %b", k, level_r, level_nr, exp);
            else passes++;
        end
        checks++;
        if (q_r.size() != 0 || q_nr.size() != 0)
            $display("FAIL clean_pending: %0d/%0d pulses outstanding, expected 0", q_r.size(), q_nr.size());
        else passes++;
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 32; k++) begin
            btn_raw = (k < 20) && (k % 4 != 3);
            @(negedge clk);
            checks++;
            if (level_r !== 1'b0 || level_nr !== 1'b0)
                $display("FAIL bounce_level edge %0d: level=%b/%b, expected 0", k, level_r, level_nr);
            else passes++;
        end
    endtask

    task automatic test_auto_repeat();
        int base;
        logic exp;
        base = cyc + 1;
        q_r.push_back(base + 5);
        q_r.push_back(base + 15);
        q_r.push_back(base + 20);
        q_r.push_back(base + 25);
        q_r.push_back(base + 30);
        q_nr.push_back(base + 5);
        for (int k = 0; k < 46; k++) begin
            btn_raw = (k < 32);
            @(negedge clk);
            exp = (k >= 5 && k < 37);
            checks++;
            if (level_r !== exp || level_nr !== exp)
                $display("FAIL repeat_level edge %0d: level=%b/%b, expected %b", k, level_r, level_nr, exp);
            else passes++;
        end
        checks++;
        if (q_r.size() != 0 || q_nr.size() != 0)
            $display("FAIL repeat_pending: %0d/%0d pulses outstanding, expected 0", q_r.size(), q_nr.size());
        else passes++;
    endtask

    task automatic test_release_glitch();
        int base;
        logic exp;
        base = cyc + 1;
        // Glitch drops HELD at edge 10, re-enters at edge 12; repeat restarts 10 later.
        q_r.push_back(base + 5);
        q_r.push_back(base + 22);
        q_nr.push_back(base + 5);
        for (int k = 0; k < 36; k++) begin
            btn_raw = (k < 8) || (k >= 10 && k < 24);
            @(negedge clk);
            exp = (k >= 5 && k < 29);
            checks++;
            if (level_r !== exp || level_nr !== exp)
                $display("FAIL glitch_level edge %0d: level=%b/%b, expected %b", k, level_r, level_nr, exp);
            else passes++;
        end
        checks++;
        if (q_r.size() != 0 || q_nr.size() != 0)
            $display("FAIL glitch_pending: %0d/%0d pulses outstanding, expected 0", q_r.size(), q_nr.size());
        else passes++;
    endtask

    task automatic test_reset_mid();
        int base;
        logic exp;
        base = cyc + 1;
        // Reset covers edges 3-4; re-qualification needs sync (2) + 4 samples from edge 5.
        q_r.push_back(base + 10);
        q_nr.push_back(base + 10);
        for (int k = 0; k < 30; k++) begin
            btn_raw = (k < 14);
            reset   = !(k == 3 || k == 4);
            @(negedge clk);
            exp = (k >= 10 && k < 19);
            checks++;
            if (level_r !== exp || level_nr !== exp)
                $display("FAIL resetmid_level edge %0d: level=%b/%b, expected %b", k, level_r, level_nr, exp);
            else passes++;
        end
        checks++;
        if (q_r.size() != 0 || q_nr.size() != 0)
            $display("FAIL resetmid_pending: %0d/%0d pulses outstanding, expected 0", q_r.size(), q_nr.size());
        else passes++;
    endtask

    task automatic test_async_reset();
        int base;
        logic exp;
        base = cyc + 1;
        q_r.push_back(base + 5);
        q_nr.push_back(base + 5);
        for (int k = 0; k < 10; k++) begin
            btn_raw = 1'b1;
            @(negedge clk);
            exp = (k >= 5);
            checks++;
            if (level_r !== exp || level_nr !== exp)
                $display("FAIL async_pre_level edge %0d: level=%b/%b, expected %b", k, level_r, level_nr, exp);
            else passes++;
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (level_r !== 1'b0 || level_nr !== 1'b0 || t_r !== 1'b0 || t_nr !== 1'b0)
            $display("FAIL async_reset: level=%b/%b t=%b/%b without clock edge, expected 0",
                     level_r, level_nr, t_r, t_nr);
        else passes++;
        for (int k = 10; k < 24; k++) begin
            @(negedge clk);
            btn_raw = 1'b0;
            reset   = (k >= 12);
            checks++;
            if (level_r !== 1'b0 || level_nr !== 1'b0 || t_r !== 1'b0 || t_nr !== 1'b0)
                $display("FAIL async_post cycle %0d: level=%b/%b t=%b/%b, expected 0",
                         k, level_r, level_nr, t_r, t_nr);
            else passes++;
        end
        checks++;
        if (q_r.size() != 0 || q_nr.size() != 0)
            $display("FAIL async_pending: %0d/%0d pulses outstanding, expected 0", q_r.size(), q_nr.size());
        else passes++;
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 1'b0;
        #2 reset = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_glitch();
        test_reset_mid();
        test_async_reset();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
